// File: rtl/taillight_pkg.sv
// Shared types for the tail-light tile: FSM state encoding and sweep-mode values.
package taillight_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEQ_L  = 2'd1,
    SEQ_R  = 2'd2,
    HAZ_ON = 2'd3
  } state_e;

  localparam logic MODE_FILL  = 1'b0;
  localparam logic MODE_CHASE = 1'b1;

endpackage

// File: rtl/seq_taillight_ctrl_tick_gen.sv
// Free-running divider producing a one-clock step pulse every SYSTEM_FREQ/HZ clocks.
module tick_gen #(
  parameter int unsigned SYSTEM_FREQ = 6250,
  parameter int unsigned HZ          = 8
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int unsigned CYCLES = SYSTEM_FREQ / HZ;
  localparam int unsigned CNT_W  = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam int unsigned LAST   = CYCLES - 32'd1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_last_s;

  // Terminal count is compared at 32 bits so CYCLES-1 is never truncated.
  assign at_last_s = (32'(cnt_q) == LAST);
  assign tick      = at_last_s;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (at_last_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seq_taillight_ctrl.sv
// Tail-light sequencer: turn sweeps (fill/chase), hazard flash and brake overlay
// for LAMPS lamps per side, stepping at the tick_gen rate.
module seq_taillight_ctrl
  import taillight_pkg::*;
#(
  parameter int unsigned LAMPS       = 3,
  parameter int unsigned SYSTEM_FREQ = 6250,
  parameter int unsigned HZ          = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             left,
  input  logic             right,
  input  logic             haz,
  input  logic             brake,
  input  logic             mode,
  output logic [LAMPS-1:0] lights_l,
  output logic [LAMPS-1:0] lights_r,
  output logic             busy
);

  localparam int unsigned     KW     = $clog2(LAMPS + 1);
  localparam logic [LAMPS-1:0] ALL_ON = '1;

  state_e          state_q;
  state_e          state_d;
  logic [KW-1:0]   k_q;
  logic [KW-1:0]   k_d;
  logic            mode_q;
  logic            mode_d;
  logic            haz_phase_q;
  logic            haz_phase_d;
  logic            tick_s;
  logic            haz_req_s;
  logic [LAMPS-1:0] sweep_s;
  logic [LAMPS-1:0] brake_s;

  tick_gen #(
    .SYSTEM_FREQ(SYSTEM_FREQ),
    .HZ         (HZ)
  ) u_tick_gen (
    .clk    (clk),
    .reset_n(reset_n),
    .tick   (tick_s)
  );

  // Active-side pattern for step k (1..LAMPS); k = 0 lights nothing.
  function automatic logic [LAMPS-1:0] sweep_pattern(input logic [KW-1:0] k,
                                                     input logic          chase);
    logic [LAMPS-1:0] p;
    p = '0;
    for (int i = 0; i < int'(LAMPS); i++) begin
      if (chase == MODE_CHASE) begin
        p[i] = ((i + 1) == int'(k));
      end else begin
        p[i] = (i < int'(k));
      end
    end
    return p;
  endfunction

  assign haz_req_s = haz | (left & right);

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    mode_d      = mode_q;
    haz_phase_d = haz_phase_q;
    if (tick_s) begin
      haz_phase_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (haz_req_s) begin
            state_d = HAZ_ON;
            k_d     = '0;
          end else if (left) begin
            state_d = SEQ_L;
            k_d     = KW'(1);
            mode_d  = mode;
          end else if (right) begin
            state_d = SEQ_R;
            k_d     = KW'(1);
            mode_d  = mode;
          end else begin
            state_d = IDLE;
          end
        end
        SEQ_L, SEQ_R: begin
          if (haz) begin
            state_d = HAZ_ON;
            k_d     = '0;
          end else if (k_q < KW'(LAMPS)) begin
            k_d = k_q + KW'(1);
          end else begin
            state_d = IDLE;
            k_d     = '0;
          end
        end
        HAZ_ON: begin
          // Off-phase is dark only while the hazard request is still held.
          state_d     = IDLE;
          k_d         = '0;
          haz_phase_d = haz_req_s;
        end
        default: begin
          state_d = IDLE;
          k_d     = '0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      mode_q      <= MODE_FILL;
      haz_phase_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      mode_q      <= mode_d;
      haz_phase_q <= haz_phase_d;
    end
  end

  assign sweep_s = sweep_pattern(k_q, mode_q);
  assign brake_s = brake ? ALL_ON : '0;

  // Brake is live so the overlay responds without waiting for a tick.
  always_comb begin
    lights_l = '0;
    lights_r = '0;
    busy     = 1'b0;
    if (!reset_n) begin
      lights_l = '0;
      lights_r = '0;
      busy     = 1'b0;
    end else begin
      busy = (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (haz_phase_q) begin
            lights_l = '0;
            lights_r = '0;
          end else begin
            lights_l = brake_s;
            lights_r = brake_s;
          end
        end
        SEQ_L: begin
          lights_l = sweep_s;
          lights_r = brake_s;
        end
        SEQ_R: begin
          lights_l = brake_s;
          lights_r = sweep_s;
        end
        HAZ_ON: begin
          lights_l = ALL_ON;
          lights_r = ALL_ON;
        end
        default: begin
          lights_l = '0;
          lights_r = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_taillight_ctrl.sv
// Randomised scoreboard bench for seq_taillight_ctrl (LAMPS=3, CYCLES=5) with directed openers.
module tb_seq_taillight_ctrl;

  localparam int L = 3;

  logic         clk;
  logic         reset_n;
  logic         left;
  logic         right;
  logic         haz;
  logic         brake;
  logic         mode;
  logic [L-1:0] lights_l;
  logic [L-1:0] lights_r;
  logic         busy;

  typedef struct packed {
    logic [L-1:0] l;
    logic [L-1:0] r;
    logic         b;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: what the lamps show, not how the RTL encodes it.
  // side: 0 = nothing running, 1 = left sweep, 2 = right sweep, 3 = hazard lit.
  int   m_edges;
  int   m_side;
  int   m_step;
  bit   m_chase;
  bit   m_dark;

  seq_taillight_ctrl #(
    .LAMPS      (L),
    .SYSTEM_FREQ(40),
    .HZ         (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .left    (left),
    .right   (right),
    .haz     (haz),
    .brake   (brake),
    .mode    (mode),
    .lights_l(lights_l),
    .lights_r(lights_r),
    .busy    (busy)
  );

  initial begin
    clk = 1'b0;
    #20;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input exp_t e);
    checks++;
    if ({lights_l, lights_r, busy} !== {e.l, e.r, e.b}) begin
      errors++;
      $display("FAIL %s: got l=%b r=%b busy=%b, expected l=%b r=%b busy=%b",
               name, lights_l, lights_r, busy, e.l, e.r, e.b);
    end
  endtask

  function automatic void model_reset();
    m_edges = 0;
    m_side  = 0;
    m_step  = 0;
    m_chase = 1'b0;
    m_dark  = 1'b0;
  endfunction

  function automatic void model_edge();
    bit hreq;
    m_edges++;
    if (m_edges % 5 != 0) return;
    hreq = haz | (left & right);
    if (m_side == 3) begin
      m_side = 0;
      m_step = 0;
      m_dark = hreq;
    end else if (m_side == 0) begin
      m_dark = 1'b0;
      if (hreq) m_side = 3;
      else if (left) begin m_side = 1; m_step = 1; m_chase = mode; end
      else if (right) begin m_side = 2; m_step = 1; m_chase = mode; end
    end else begin
      m_dark = 1'b0;
      if (haz) begin m_side = 3; m_step = 0; end
      else if (m_step < L) m_step++;
      else begin m_side = 0; m_step = 0; end
    end
  endfunction

  function automatic exp_t expected();
    exp_t e;
    int   all_on;
    int   brk;
    int   sw;
    all_on = (1 << L) - 1;
    brk    = brake ? all_on : 0;
    sw     = 0;
    if (m_side == 1 || m_side == 2)
      sw = m_chase ? (1 << (m_step - 1)) : ((1 << m_step) - 1);
    e = '0;
    if (!reset_n) return e;
    case (m_side)
      1: begin e.l = L'(sw); e.r = L'(brk); end
      2: begin e.l = L'(brk); e.r = L'(sw); end
      3: begin e.l = L'(all_on); e.r = L'(all_on); end
      default: begin
        e.l = m_dark ? '0 : L'(brk);
        e.r = m_dark ? '0 : L'(brk);
      end
    endcase
    e.b = (m_side != 0);
    return e;
  endfunction

  // One clock of stimulus: advance model at the edge, then apply new inputs and queue the expectation.
  task automatic cycle(input logic l, input logic r, input logic h, input logic b,
                       input logic m, input logic rn);
    @(posedge clk);
    if (reset_n) model_edge();
    #1;
    left    = l;
    right   = r;
    haz     = h;
    brake   = b;
    mode    = m;
    reset_n = rn;
    if (!rn) model_reset();
    exp_q.push_back(expected());
    if (!rn) begin
      #1;
      check("async_reset", exp_t'(0));
    end
  endtask

  // Monitor: the DUT presents lamps every cycle; compare mid-cycle against the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) check("lamps", exp_q.pop_front());
    end
  end

  initial begin
    logic l, r, h, b, m, rn;
    int   guard;
    reset_n = 1'b0;
    left    = 1'b1;
    right   = 1'b0;
    haz     = 1'b1;
    brake   = 1'b1;
    mode    = 1'b0;
    model_reset();
    #2;
    check("reset_no_clk", exp_t'(0));

    repeat (2) cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    // Release with left held, fill: 001, 011, 111, idle, 001 ...
    repeat (25) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    // Right, chase, mode flipped mid-sequence.
    repeat (12) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (20) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (15) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    // Left, then hazard held with brake (brake dark in off-phase).
    repeat (10) cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (25) cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    repeat (10) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    // left & right together acts as hazard.
    repeat (20) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (10) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset mid right-sweep at k = 2, then restart with right held.
    guard = 0;
    while (!(m_side == 2 && m_step == 2) && guard < 60) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      guard++;
    end
    checks++;
    if (!(m_side == 2 && m_step == 2)) begin
      errors++;
      $display("FAIL reach_seq_r_k2: not reached within %0d cycles, required 60", guard);
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (12) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    l = 1'b0; r = 1'b0; h = 1'b0; b = 1'b0; m = 1'b0;
    repeat (800) begin
      if ($urandom_range(0, 3) == 0) begin
        l = ($urandom_range(0, 2) == 0);
        r = ($urandom_range(0, 2) == 0);
        h = ($urandom_range(0, 11) == 0);
        b = $urandom_range(0, 1);
        m = $urandom_range(0, 1);
      end
      rn = ($urandom_range(0, 299) != 0);
      cycle(l, r, h, b, m, rn);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
